// File: rtl/man_tx_dy.sv
// Manchester transmitter for the optical link: start cell, 48-bit payload and
// CRC-16 framed onto an idle-high line, followed by an idle gap.
module man_tx_dy #(
    parameter int CLK_DIV  = 24,
    parameter int GAP_CLKS = 312
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_i,
    input  logic [15:0] udc_i,
    input  logic [15:0] staa_i,
    input  logic [15:0] stab_i,
    output logic        M_T,
    output logic        busy_o,
    output logic        done_o,
    output logic        drop_o
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam logic [HW-1:0] HC_LAST  = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_CRC, S_GAP
    } state_t;

    state_t          r_state, w_state_n;
    logic [HW-1:0]   r_hcnt, w_hcnt_n;
    logic            r_half, w_half_n;
    logic [6:0]      r_cell, w_cell_n;
    logic [GW-1:0]   r_gap, w_gap_n;
    logic [47:0]     r_sr, w_sr_n;
    logic [15:0]     r_crc, w_crc_n;
    logic            r_mt, r_busy, r_done, r_drop;
    logic            w_mt_n, w_busy_n, w_done_n, w_drop_n;
    logic            w_bit_n, w_hend, w_cend, w_fb;

    assign w_hend = (r_hcnt == HC_LAST);
    assign w_cend = w_hend & r_half;
    assign w_fb   = r_sr[47] ^ r_crc[15];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:  if (send_i) w_state_n = S_START;
            S_START: if (w_cend) w_state_n = S_DATA;
            S_DATA:  if (w_cend && r_cell == 7'd48) w_state_n = S_CRC;
            S_CRC:   if (w_cend && r_cell == 7'd64) w_state_n = S_GAP;
            S_GAP:   if (r_gap == GAP_LAST) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (reset) w_state_n = S_IDLE;
    end

    // CRC folds in each payload bit as its cell finishes on the line
    always_comb begin
        w_hcnt_n = r_hcnt;
        w_half_n = r_half;
        w_cell_n = r_cell;
        w_gap_n  = r_gap;
        w_sr_n   = r_sr;
        w_crc_n  = r_crc;
        unique case (r_state)
            S_IDLE: begin
                w_hcnt_n = '0;
                w_half_n = 1'b0;
                w_cell_n = '0;
                w_gap_n  = '0;
                w_crc_n  = '0;
                if (send_i) w_sr_n = {stab_i, staa_i, udc_i};
            end
            S_START, S_DATA, S_CRC: begin
                w_hcnt_n = w_hend ? '0 : r_hcnt + 1'b1;
                if (w_hend) w_half_n = ~r_half;
                if (w_cend && r_cell != 7'd64) w_cell_n = r_cell + 7'd1;
                if (w_cend && r_state == S_DATA) begin
                    w_sr_n  = {r_sr[46:0], 1'b0};
                    w_crc_n = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
                end
                if (w_cend && r_state == S_CRC) w_crc_n = {r_crc[14:0], 1'b0};
            end
            S_GAP: if (r_gap != GAP_LAST) w_gap_n = r_gap + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_half <= 1'b0;
            r_cell <= '0;
            r_gap  <= '0;
            r_sr   <= '0;
            r_crc  <= '0;
        end else begin
            r_hcnt <= w_hcnt_n;
            r_half <= w_half_n;
            r_cell <= w_cell_n;
            r_gap  <= w_gap_n;
            r_sr   <= w_sr_n;
            r_crc  <= w_crc_n;
        end
    end

    // line level is computed from next-cycle state so M_T can be a flop
    always_comb begin
        unique case (w_state_n)
            S_DATA:  w_bit_n = w_sr_n[47];
            S_CRC:   w_bit_n = w_crc_n[15];
            default: w_bit_n = 1'b1;
        endcase
        w_mt_n = 1'b1;
        if (w_state_n inside {S_START, S_DATA, S_CRC})
            w_mt_n = w_half_n ? w_bit_n : ~w_bit_n;
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (r_state == S_GAP) && (w_state_n == S_IDLE);
        w_drop_n = send_i && (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mt   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_mt   <= w_mt_n;
            r_busy <= w_busy_n;
            r_done <= w_done_n;
            r_drop <= w_drop_n;
        end
    end

    assign M_T    = r_mt;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign drop_o = r_drop;

endmodule

// File: tb/tb_man_tx_dy.sv
// Scoreboard bench for man_tx_dy: a frame/timing model queues expectations,
// a negedge monitor decodes the line and compares.
module tb_man_tx_dy;

    localparam int CD    = 24;
    localparam int GAP   = 312;
    localparam int FRAME = 130 * CD;

    typedef struct {
        int         start;
        logic [64:0] bits;
    } frm_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_i = 1'b0;
    logic [15:0] udc_i = '0;
    logic [15:0] staa_i = '0;
    logic [15:0] stab_i = '0;
    logic        M_T, busy_o, done_o, drop_o;

    man_tx_dy #(.CLK_DIV(CD), .GAP_CLKS(GAP)) dut (
        .clk    (clk),
        .reset  (reset),
        .send_i (send_i),
        .udc_i  (udc_i),
        .staa_i (staa_i),
        .stab_i (stab_i),
        .M_T    (M_T),
        .busy_o (busy_o),
        .done_o (done_o),
        .drop_o (drop_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC as the remainder of payload*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_ref(input logic [47:0] d);
        logic [63:0] r;
        r = {d, 16'h0000};
        for (int i = 63; i >= 16; i--)
            if (r[i]) r = r ^ ({47'b0, 17'h11021} << (i - 16));
        return r[15:0];
    endfunction

    frm_t fq[$];
    int   dq[$];

    // monitor
    int          phase = 0;
    int          cnt = 0;
    int          frames = 0;
    int          aborted = 0;
    int          last_done = -1;
    int          h;
    bit          rst_prev = 1'b1;
    logic [64:0] cur = '0;
    logic [64:0] dec = '0;
    logic [64:0] last_dec = '0;
    logic        exp_mt, exp_busy, exp_done, exp_drop;
    frm_t        fm;

    always @(negedge clk) begin
        exp_drop = 1'b0;
        if (dq.size() > 0 && dq[0] == cyc) begin
            exp_drop = 1'b1;
            void'(dq.pop_front());
        end
        if (done_o === 1'b1) last_done = cyc;
        exp_mt   = 1'b1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (rst_prev) begin
            if (phase != 0) aborted++;
            phase = 0;
        end else begin
            if (phase == 0) begin
                if (M_T === 1'b0) begin
                    if (fq.size() == 0) begin
                        chk("spurious_frame", 96'd1, 96'd0);
                    end else begin
                        fm = fq.pop_front();
                        chk("start_cycle", 96'(cyc), 96'(fm.start));
                        cur   = fm.bits;
                        dec   = '0;
                        phase = 1;
                        cnt   = 0;
                    end
                end else if (fq.size() > 0 && cyc > fq[0].start) begin
                    chk("frame_missing", 96'd0, 96'd1);
                    void'(fq.pop_front());
                end
            end
            case (phase)
                1: begin
                    h = cnt / CD;
                    exp_mt   = (h % 2 == 1) ? cur[64 - h/2] : ~cur[64 - h/2];
                    exp_busy = 1'b1;
                    if (cnt % (2*CD) == 0) dec[64 - cnt/(2*CD)] = ~M_T;
                end
                2: exp_busy = 1'b1;
                3: exp_done = 1'b1;
                default: ;
            endcase
        end
        chk("M_T", 96'(M_T), 96'(exp_mt));
        chk("busy_o", 96'(busy_o), 96'(exp_busy));
        chk("done_o", 96'(done_o), 96'(exp_done));
        chk("drop_o", 96'(drop_o), 96'(exp_drop));
        if (!rst_prev) begin
            case (phase)
                1: begin
                    cnt++;
                    if (cnt == FRAME) begin
                        chk("frame_decode", 96'(dec), 96'(cur));
                        last_dec = dec;
                        frames++;
                        phase = 2;
                        cnt   = 0;
                    end
                end
                2: begin
                    cnt++;
                    if (cnt == GAP) phase = 3;
                end
                3: phase = 0;
                default: ;
            endcase
        end
        rst_prev = reset;
    end

    // stimulus and timing model
    int model_free = 0;
    int n_frames = 0;
    int t0;
    int prev_done;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] b, input logic [15:0] a,
                        input logic [15:0] u);
        frm_t e;
        stab_i = b;
        staa_i = a;
        udc_i  = u;
        send_i = 1'b1;
        if (cyc >= model_free) begin
            e.start = cyc + 1;
            e.bits  = {1'b1, b, a, u, crc_ref({b, a, u})};
            fq.push_back(e);
            model_free = cyc + 1 + FRAME + GAP;
            n_frames++;
        end else begin
            dq.push_back(cyc + 1);
        end
        step(1);
        send_i = 1'b0;
    endtask

    task automatic scramble();
        stab_i = 16'($urandom);
        staa_i = 16'($urandom);
        udc_i  = 16'($urandom);
    endtask

    task automatic wait_idle();
        step(model_free - cyc + 1);
    endtask

    initial begin
        step(5);
        reset = 1'b0;
        model_free = cyc;
        step(100);

        t0 = cyc;
        send(16'h0000, 16'h0000, 16'h0000);
        wait_idle();
        chk("done_latency", 96'(last_done - t0), 96'(FRAME + GAP + 1));
        chk("crc_zero", 96'(last_dec[15:0]), 96'h0000);

        send(16'h0000, 16'h0000, 16'h0001);
        wait_idle();
        chk("last_data_bit", 96'(last_dec[16]), 96'd1);
        chk("crc_0001", 96'(last_dec[15:0]), 96'h1021);

        send(16'hA5C3, 16'h1234, 16'h0FF0);
        step(10);
        scramble();
        step(20 * CD);
        send(16'($urandom), 16'($urandom), 16'($urandom));
        step(7);
        scramble();
        wait_idle();

        send(16'($urandom), 16'($urandom), 16'($urandom));
        for (int k = 0; k < 3; k++) begin
            step($urandom_range(5, FRAME));
            send(16'($urandom), 16'($urandom), 16'($urandom));
            step(model_free - cyc);
            send(16'($urandom), 16'($urandom), 16'($urandom));
        end
        wait_idle();

        send(16'($urandom), 16'($urandom), 16'($urandom));
        step(110 * CD);
        prev_done = last_done;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_free = cyc;
        step(FRAME + GAP + 10);
        chk("no_done_after_abort", 96'(last_done), 96'(prev_done));
        chk("aborted", 96'(aborted), 96'd1);

        send(16'($urandom), 16'($urandom), 16'($urandom));
        wait_idle();
        step(20);

        chk("frames_done", 96'(frames), 96'(n_frames - 1));
        chk("queues_empty", 96'(fq.size() + dq.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
